// File: rtl/pmod_edge_meter.sv
// Rising-edge counter for one asynchronous PMOD input over a programmable gate window.
// Captured counts are presented through a single-entry valid/ready result register.
module pmod_edge_meter #(
    parameter int GATE_CYCLES = 48000000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sig_in,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow,
    output logic             dropped
);

    localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   dly_r;
    logic                   edge_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_inc_s;
    logic                   cnt_full_s;
    logic                   sat_r;
    logic                   sat_hit_s;
    logic [TMR_W-1:0]       timer_r;
    logic                   capture_s;

    assign edge_s     = sync_r[SYNC_STAGES-1] & ~dly_r;
    assign cnt_full_s = &cnt_r;
    assign sat_hit_s  = edge_s & cnt_full_s;
    assign cnt_inc_s  = (edge_s && !cnt_full_s) ? (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_r;

    // Synchroniser chain followed by the edge-detect delay flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            dly_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            dly_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; stop outranks capture in the final gate cycle.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GATE;
                end
            end
            ST_GATE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (timer_r == {TMR_W{1'b0}}) begin
                    capture_s   = 1'b1;
                    state_nxt_s = cont ? ST_ARM : ST_IDLE;
                end else begin
                    state_nxt_s = ST_GATE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Edge counter, saturation flag and gate timer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r   <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
            timer_r <= {TMR_W{1'b0}};
        end else begin
            case (state_r)
                ST_ARM: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    sat_r   <= 1'b0;
                    timer_r <= TMR_LOAD;
                end
                ST_GATE: begin
                    cnt_r   <= cnt_inc_s;
                    sat_r   <= sat_r | sat_hit_s;
                    timer_r <= timer_r - {{(TMR_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    cnt_r   <= cnt_r;
                    sat_r   <= sat_r;
                    timer_r <= timer_r;
                end
            endcase
        end
    end

    // Result register and handshake; a capture always wins over a plain accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result       <= {CNT_W{1'b0}};
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            dropped      <= 1'b0;
        end else if (capture_s) begin
            result       <= cnt_inc_s;
            overflow     <= sat_r | sat_hit_s;
            result_valid <= 1'b1;
            dropped      <= result_valid & ~result_ready;
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
            dropped      <= 1'b0;
        end
    end

    // Busy mirrors the state the machine is entering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_GATE);
        end
    end

endmodule
